data_sram_responder: RTL and testbench

Word-addressed data-memory slave that answers the data-side SRAM requests issued by the CPU core's execute/memory pipeline, and drives `data_ram_read_data` / `data_ram_data_ready` back into the io stage. Each accepted request, load or store, produces exactly one `data_ram_data_ready` pulse after a fixed latency, in acceptance order. This matches the io stage's pending-store counting and its wait-for-ready load completion. The block serves as the simulation and FPGA stand-in for the data SRAM behind the core.

---
 rtl/data_sram_responder_pkg.sv | 25 ++
 rtl/data_sram_responder_response_queue.sv | 86 ++++++++
 rtl/data_sram_responder.sv | 119 +++++++++++
 tb/tb_data_sram_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_params
//   Shared types and constants for the data-side SRAM responder.
//   - response_entry_t : one outstanding response (return data + countdown)
//   - data_request_t   : one request as presented by the core's memory stage
// -----------------------------------------------------------------------------
package data_sram_params;

    localparam int DATA_WORD_WIDTH = 32;
    localparam int STROBE_WIDTH    = DATA_WORD_WIDTH / 8;
    localparam int COUNTDOWN_WIDTH = 4;

    typedef struct packed {
        logic [DATA_WORD_WIDTH-1:0] data;
        logic [COUNTDOWN_WIDTH-1:0] countdown;
    } response_entry_t;

    typedef struct packed {
        logic                       write;
        logic [STROBE_WIDTH-1:0]    strobe;
        logic [31:0]                address;
        logic [DATA_WORD_WIDTH-1:0] write_data;
    } data_request_t;

endpackage

// File: rtl/data_sram_responder_response_queue.sv
// -----------------------------------------------------------------------------
// response_queue
//   FIFO of response entries. Every entry carries a countdown that is loaded
//   with RESPONSE_LATENCY-1 on push and decrements each cycle down to zero;
//   the owner pops the head once its countdown has reached zero.
//
// Ports
//   clock, reset_n : clock and asynchronous active-low reset
//   i_push         : write i_push_data into the tail (never asserted when full)
//   i_push_data    : response data for the new entry
//   i_pop          : drop the head entry (never asserted when empty)
//   o_head         : head entry (data + countdown), valid when !o_empty
//   o_full         : all QUEUE_DEPTH slots occupied (registered pointers only)
//   o_empty        : no entry outstanding
// -----------------------------------------------------------------------------
module response_queue
    import data_sram_params::*;
#(
    parameter int QUEUE_DEPTH      = 4,
    parameter int RESPONSE_LATENCY = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [DATA_WORD_WIDTH-1:0] i_push_data,
    input  logic                       i_pop,
    output response_entry_t            o_head,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int IW = $clog2(QUEUE_DEPTH);
    localparam int PW = IW + 1;
    localparam logic [COUNTDOWN_WIDTH-1:0] INIT_COUNT = COUNTDOWN_WIDTH'(RESPONSE_LATENCY - 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [DATA_WORD_WIDTH-1:0] r_data  [QUEUE_DEPTH];
    logic [COUNTDOWN_WIDTH-1:0] r_count [QUEUE_DEPTH];

    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[IW-1:0];
    assign w_rd_idx = r_rd_ptr[IW-1:0];

    assign o_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[IW] != r_rd_ptr[IW]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);

    assign o_head.data      = r_data[w_rd_idx];
    assign o_head.countdown = r_count[w_rd_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Free slots also count down; harmless, since a push reloads them.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (i_push && (w_wr_idx == IW'(i))) begin
                    r_count[i] <= INIT_COUNT;
                end else if (r_count[i] != '0) begin
                    r_count[i] <= r_count[i] - COUNTDOWN_WIDTH'(1);
                end
            end
        end
    end

    // Payload storage needs no reset: a slot is only read after being pushed.
    always_ff @(posedge clock) begin
        if (i_push) begin
            r_data[w_wr_idx] <= i_push_data;
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//   Word-addressed data memory answering the core's data-side SRAM requests.
//   Every accepted request (load or store) yields exactly one
//   data_ram_data_ready pulse RESPONSE_LATENCY cycles later, in acceptance
//   order. Loads return the whole addressed word; stores return 0.
//
// Handshake: a request transfers on a rising edge where request_valid and
//   request_ready are both high. request_ready is derived from registered
//   queue pointers only, so it never depends on this cycle's inputs or pop.
//   The requester holds its request stable until it transfers.
//
// Ports
//   clock, reset_n        : clock and asynchronous active-low reset
//   request_valid         : request present
//   request_write         : 1 = store, 0 = load
//   request_strobe        : byte-lane enables for stores
//   request_address       : byte address, word index in [MEMORY_ADDRESS_BITS+1:2]
//   request_write_data    : lane-aligned store data
//   request_ready         : request queue has room
//   data_ram_data_ready   : one-cycle response pulse
//   data_ram_read_data    : load data on a load response, else 0
// -----------------------------------------------------------------------------
module data_sram_responder
    import data_sram_params::*;
#(
    parameter int MEMORY_ADDRESS_BITS = 10,
    parameter int RESPONSE_LATENCY    = 2,
    parameter int QUEUE_DEPTH         = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       request_valid,
    input  logic                       request_write,
    input  logic [STROBE_WIDTH-1:0]    request_strobe,
    input  logic [31:0]                request_address,
    input  logic [DATA_WORD_WIDTH-1:0] request_write_data,
    output logic                       request_ready,
    output logic                       data_ram_data_ready,
    output logic [DATA_WORD_WIDTH-1:0] data_ram_read_data
);

    localparam int MEMORY_WORDS = 2 ** MEMORY_ADDRESS_BITS;

    // Memory contents are deliberately not reset.
    logic [DATA_WORD_WIDTH-1:0] r_memory [MEMORY_WORDS];

    logic                           r_rsp_valid;
    logic [DATA_WORD_WIDTH-1:0]     r_rsp_data;

    data_request_t                  w_request;
    logic                           w_accept;
    logic [MEMORY_ADDRESS_BITS-1:0] w_word_index;
    logic [DATA_WORD_WIDTH-1:0]     w_read_word;
    logic [DATA_WORD_WIDTH-1:0]     w_push_data;
    response_entry_t                w_head;
    logic                           w_full;
    logic                           w_empty;
    logic                           w_pop;
    logic                           w_unused_bits;

    assign w_request.write      = request_write;
    assign w_request.strobe     = request_strobe;
    assign w_request.address    = request_address;
    assign w_request.write_data = request_write_data;

    // Byte offset and bits above the memory size do not select anything.
    assign w_unused_bits = ^{w_request.address[1:0],
                             w_request.address[31:MEMORY_ADDRESS_BITS+2]};

    assign request_ready = !w_full;
    assign w_accept      = request_valid && !w_full;
    assign w_word_index  = w_request.address[MEMORY_ADDRESS_BITS+1:2];

    // Read is taken before this edge's write lands, i.e. the pre-store word.
    assign w_read_word = r_memory[w_word_index];
    assign w_push_data = w_request.write ? '0 : w_read_word;

    always_ff @(posedge clock) begin
        if (w_accept && w_request.write) begin
            for (int lane = 0; lane < STROBE_WIDTH; lane++) begin
                if (w_request.strobe[lane]) begin
                    r_memory[w_word_index][8*lane +: 8] <= w_request.write_data[8*lane +: 8];
                end
            end
        end
    end

    // Head leaves once its latency has elapsed.
    assign w_pop = !w_empty && (w_head.countdown == '0);

    response_queue #(
        .QUEUE_DEPTH      (QUEUE_DEPTH),
        .RESPONSE_LATENCY (RESPONSE_LATENCY)
    ) u_response_queue (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_push      (w_accept),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_pop;
            r_rsp_data  <= w_pop ? w_head.data : '0;
        end
    end

    assign data_ram_data_ready = r_rsp_valid;
    assign data_ram_read_data  = r_rsp_data;

endmodule

// File: tb/tb_data_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_data_sram_responder
//   Two responders share clock and reset: instance 0 uses the default
//   parameters (latency 2, depth 4), instance 1 uses latency 8, depth 4 so the
//   queue can fill. A reference model predicts each response: a request seen
//   on edge E answers in cycle max(E + latency, previous answer + 1), the queue
//   holds the requests not yet answered, and a byte-array memory supplies
//   load data.
// -----------------------------------------------------------------------------
module tb_data_sram_responder;

    localparam int NI   = 2;
    localparam int LAT0 = 2;
    localparam int DEP0 = 4;
    localparam int LAT1 = 8;
    localparam int DEP1 = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rq_valid  [NI];
    logic        rq_write  [NI];
    logic [3:0]  rq_strobe [NI];
    logic [31:0] rq_addr   [NI];
    logic [31:0] rq_wdata  [NI];
    logic        rq_ready  [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_data  [NI];

    // Scoreboard: expected data and expected response cycle, per instance.
    logic [31:0] exp_q     [NI][$];
    int          exp_cyc_q [NI][$];
    logic [31:0] mdl_mem   [NI][1024];
    int          last_resp [NI];
    int          cyc;
    int          checks;
    int          errors;

    always #5 clock = ~clock;

    data_sram_responder #(
        .MEMORY_ADDRESS_BITS (10),
        .RESPONSE_LATENCY    (LAT0),
        .QUEUE_DEPTH         (DEP0)
    ) dut0 (
        .clock               (clock),
        .reset_n             (reset_n),
        .request_valid       (rq_valid[0]),
        .request_write       (rq_write[0]),
        .request_strobe      (rq_strobe[0]),
        .request_address     (rq_addr[0]),
        .request_write_data  (rq_wdata[0]),
        .request_ready       (rq_ready[0]),
        .data_ram_data_ready (rsp_valid[0]),
        .data_ram_read_data  (rsp_data[0])
    );

    data_sram_responder #(
        .MEMORY_ADDRESS_BITS (10),
        .RESPONSE_LATENCY    (LAT1),
        .QUEUE_DEPTH         (DEP1)
    ) dut1 (
        .clock               (clock),
        .reset_n             (reset_n),
        .request_valid       (rq_valid[1]),
        .request_write       (rq_write[1]),
        .request_strobe      (rq_strobe[1]),
        .request_address     (rq_addr[1]),
        .request_write_data  (rq_wdata[1]),
        .request_ready       (rq_ready[1]),
        .data_ram_data_ready (rsp_valid[1]),
        .data_ram_read_data  (rsp_data[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int dep_of(input int d);
        return (d == 0) ? DEP0 : DEP1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // One negedge worth of monitoring for instance d (cyc = edges so far).
    task automatic monitor_step(input int d);
        int          occ;
        int          rc;
        logic [9:0]  idx;
        logic [31:0] ed;
        int          ec;
        logic [31:0] rdata;
        if (rsp_valid[d]) begin
            if (exp_q[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse_i%0d cycle=%0d actual=1 required=0", d, cyc);
            end else begin
                ed = exp_q[d].pop_front();
                ec = exp_cyc_q[d].pop_front();
                check($sformatf("pulse_data_i%0d", d), rsp_data[d], ed);
                check($sformatf("pulse_cycle_i%0d", d), cyc, ec);
            end
        end else begin
            check($sformatf("idle_data_i%0d", d), rsp_data[d], 32'h0);
            if (exp_cyc_q[d].size() != 0 && exp_cyc_q[d][0] <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse_i%0d cycle=%0d actual=0 required=1", d, cyc);
                ed = exp_q[d].pop_front();
                ec = exp_cyc_q[d].pop_front();
            end
        end
        occ = 0;
        for (int i = 0; i < exp_cyc_q[d].size(); i++) begin
            if (exp_cyc_q[d][i] > cyc) occ++;
        end
        check($sformatf("request_ready_i%0d", d), {31'h0, rq_ready[d]}, {31'h0, (occ < dep_of(d))});
        if (rq_valid[d] && rq_ready[d]) begin
            idx = rq_addr[d][11:2];
            if (rq_write[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (rq_strobe[d][b]) mdl_mem[d][idx][8*b +: 8] = rq_wdata[d][8*b +: 8];
                end
                rdata = 32'h0;
            end else begin
                rdata = mdl_mem[d][idx];
            end
            rc = cyc + 1 + lat_of(d);
            if (last_resp[d] + 1 > rc) rc = last_resp[d] + 1;
            last_resp[d] = rc;
            exp_q[d].push_back(rdata);
            exp_cyc_q[d].push_back(rc);
        end
    endtask

    // Drivers run from posedge+1; each issue holds the request until taken.
    task automatic issue(input int d, input logic wr, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] wd);
        logic got;
        got = 1'b0;
        rq_valid[d]  = 1'b1;
        rq_write[d]  = wr;
        rq_strobe[d] = st;
        rq_addr[d]   = a;
        rq_wdata[d]  = wd;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clock);
            got = rq_ready[d];
        end
        @(posedge clock);
        #1;
        rq_valid[d]  = 1'b0;
        rq_write[d]  = 1'b0;
        rq_strobe[d] = 4'h0;
        rq_wdata[d]  = 32'h0;
        check($sformatf("accept_i%0d", d), {31'h0, got}, 32'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        for (int d = 0; d < NI; d++) begin
            exp_q[d].delete();
            exp_cyc_q[d].delete();
            last_resp[d] = 0;
        end
        #1;
        for (int d = 0; d < NI; d++) begin
            check($sformatf("rst_pulse_i%0d", d), {31'h0, rsp_valid[d]}, 32'h0);
            check($sformatf("rst_data_i%0d", d), rsp_data[d], 32'h0);
            check($sformatf("rst_ready_i%0d", d), {31'h0, rq_ready[d]}, 32'h1);
        end
        #4;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr(input int word);
        logic [31:0] a;
        a       = $urandom();
        a[11:2] = 10'(word);
        return a;
    endfunction

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset_n = 1'b0;
        for (int d = 0; d < NI; d++) begin
            rq_valid[d]  = 1'b0;
            rq_write[d]  = 1'b0;
            rq_strobe[d] = 4'h0;
            rq_addr[d]   = 32'h0;
            rq_wdata[d]  = 32'h0;
            last_resp[d] = 0;
        end

        fork
            forever begin
                @(negedge clock);
                cyc++;
                if (reset_n) begin
                    for (int d = 0; d < NI; d++) monitor_step(d);
                end
            end
        join_none

        #2;
        for (int d = 0; d < NI; d++) begin
            check($sformatf("reset_pulse_i%0d", d), {31'h0, rsp_valid[d]}, 32'h0);
            check($sformatf("reset_data_i%0d", d), rsp_data[d], 32'h0);
            check($sformatf("reset_ready_i%0d", d), {31'h0, rq_ready[d]}, 32'h1);
        end
        #20;
        reset_n = 1'b1;
        idle(1);

        // Store then load of the same word.
        issue(0, 1'b1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF);
        issue(0, 1'b0, 4'b0000, 32'h0000_0100, 32'h0);
        idle(6);

        // Single-lane store, then load with nonzero byte offset.
        issue(0, 1'b1, 4'b0100, 32'h0000_0100, 32'h00AA_0000);
        issue(0, 1'b0, 4'b0000, 32'h0000_0103, 32'h0);
        idle(6);

        // Queue full on the long-latency instance: six requests back to back.
        for (int i = 0; i < 6; i++) begin
            issue(1, 1'b1, 4'b1111, 32'(i * 4), $urandom());
        end
        idle(20);

        // Stream of loads across the queue wrap point.
        for (int i = 0; i < 20; i++) begin
            issue(0, 1'b1, 4'b1111, 32'(i * 4), 32'(i));
        end
        idle(4);
        for (int i = 0; i < 20; i++) begin
            issue(0, 1'b0, 4'b0000, 32'(i * 4), 32'h0);
        end
        idle(6);

        // Random mixed traffic over preloaded windows.
        for (int i = 0; i < 16; i++) begin
            issue(0, 1'b1, 4'b1111, rand_addr(32 + i), $urandom());
            issue(1, 1'b1, 4'b1111, rand_addr(i), $urandom());
        end
        for (int i = 0; i < 150; i++) begin
            issue(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  rand_addr(32 + $urandom_range(0, 15)), $urandom());
            idle($urandom_range(0, 2));
        end
        for (int i = 0; i < 60; i++) begin
            issue(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  rand_addr($urandom_range(0, 15)), $urandom());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
        idle(20);

        // Reset with requests still in flight, then normal service resumes.
        for (int i = 0; i < 3; i++) begin
            issue(1, 1'b0, 4'b0000, rand_addr(i), 32'h0);
        end
        pulse_reset();
        idle(14);
        issue(0, 1'b0, 4'b0000, 32'h0000_0100, 32'h0);
        issue(1, 1'b0, 4'b0000, rand_addr(5), 32'h0);
        idle(14);

        for (int d = 0; d < NI; d++) begin
            check($sformatf("drain_i%0d", d), 32'(exp_q[d].size()), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
